// File: rtl/serializer_arbiter.sv
// Round-robin front end that shares one serializer between NUM_REQ requesters,
// launching the winner's word and reporting per-requester done/error pulses.
module serializer_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_BUS_WIDTH = 16,
    parameter int unsigned DATA_MOD_WIDTH = 4,
    parameter int unsigned BUSY_TIMEOUT   = 4,
    localparam int unsigned GRANT_W       = $clog2(NUM_REQ)
) (
    input  logic                                clk_i,
    input  logic                                arst_n_i,
    input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ*DATA_MOD_WIDTH-1:0]   req_mod_i,
    input  logic [NUM_REQ-1:0]                  req_val_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic [NUM_REQ-1:0]                  req_done_o,
    output logic [NUM_REQ-1:0]                  req_err_o,
    output logic [DATA_BUS_WIDTH-1:0]           ser_data_o,
    output logic [DATA_MOD_WIDTH-1:0]           ser_data_mod_o,
    output logic                                ser_data_val_o,
    input  logic                                ser_busy_i,
    output logic [GRANT_W-1:0]                  grant_id_o,
    output logic                                busy_o
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned SUM_W = GRANT_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        DONE,
        REJECT
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [GRANT_W-1:0]         ptr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [GRANT_W-1:0]         winner;
    logic [SUM_W-1:0]           cand;
    logic                       found;
    logic                       accept;
    logic                       bad_mod;
    logic [DATA_MOD_WIDTH-1:0]  sel_mod;
    logic [DATA_BUS_WIDTH-1:0]  data_arr [NUM_REQ];
    logic [DATA_MOD_WIDTH-1:0]  mod_arr  [NUM_REQ];

    // Unpack the flat request buses into per-requester words.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            data_arr[k] = req_data_i[k*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
            mod_arr[k]  = req_mod_i[k*DATA_MOD_WIDTH +: DATA_MOD_WIDTH];
        end
    end

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + SUM_W'(i);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!found && req_val_i[cand[GRANT_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[GRANT_W-1:0];
            end
        end
    end

    // Reset is folded in so no accept is signalled while the block is held in reset.
    assign accept  = (state_q == IDLE) && found && !ser_busy_i && arst_n_i;
    assign sel_mod = mod_arr[winner];
    assign bad_mod = (sel_mod == DATA_MOD_WIDTH'(1)) || (sel_mod == DATA_MOD_WIDTH'(2));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_ready_o    = '0;
        req_done_o     = '0;
        req_err_o      = '0;
        ser_data_val_o = 1'b0;
        busy_o         = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready_o[winner] = 1'b1;
                    state_d             = bad_mod ? REJECT : ISSUE;
                end
            end
            ISSUE: begin
                ser_data_val_o = 1'b1;
                state_d        = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (ser_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = REJECT;
                end
            end
            WAIT_DONE: begin
                if (!ser_busy_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                req_done_o[grant_id_o] = 1'b1;
                state_d                = IDLE;
            end
            REJECT: begin
                req_err_o[grant_id_o] = 1'b1;
                state_d               = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture on accept; the pointer moves even for rejected sizes so nobody starves.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr_q          <= '0;
            grant_id_o     <= '0;
            ser_data_o     <= '0;
            ser_data_mod_o <= '0;
        end else if (accept) begin
            grant_id_o     <= winner;
            ser_data_o     <= data_arr[winner];
            ser_data_mod_o <= sel_mod;
            ptr_q          <= (winner == GRANT_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            cnt_q <= '0;
        end else if ((state_q == WAIT_BUSY) && !ser_busy_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_serializer_arbiter.sv
// Cycle-accurate scoreboard bench for serializer_arbiter with a behavioural serializer.
module tb_serializer_arbiter;

    logic        clk_i;
    logic        arst_n_i;
    logic [63:0] req_data_i;
    logic [15:0] req_mod_i;
    logic [3:0]  req_val_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  req_done_o;
    logic [3:0]  req_err_o;
    logic [15:0] ser_data_o;
    logic [3:0]  ser_data_mod_o;
    logic        ser_data_val_o;
    logic        ser_busy_i;
    logic [1:0]  grant_id_o;
    logic        busy_o;

    logic        ser_mute;
    logic        ser_force;
    int unsigned ser_cnt;
    int          n_vec;
    int          n_err;

    typedef struct packed {
        logic [3:0]  rdy;
        logic        val;
        logic [3:0]  done;
        logic [3:0]  err;
        logic        busy;
        logic        gchk;
        logic [1:0]  gnt;
        logic        chk;
        logic [15:0] data;
        logic [3:0]  mod;
    } exp_t;

    exp_t exp_q[$];

    serializer_arbiter #(
        .NUM_REQ(4), .DATA_BUS_WIDTH(16), .DATA_MOD_WIDTH(4), .BUSY_TIMEOUT(4)
    ) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .req_data_i(req_data_i), .req_mod_i(req_mod_i), .req_val_i(req_val_i),
        .req_ready_o(req_ready_o), .req_done_o(req_done_o), .req_err_o(req_err_o),
        .ser_data_o(ser_data_o), .ser_data_mod_o(ser_data_mod_o),
        .ser_data_val_o(ser_data_val_o), .ser_busy_i(ser_busy_i),
        .grant_id_o(grant_id_o), .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Serializer model: latches on launch, busy for L cycles starting the next cycle.
    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ser_cnt <= 0;
        end else if (ser_cnt != 0) begin
            ser_cnt <= ser_cnt - 1;
        end else if (ser_data_val_o && !ser_mute) begin
            ser_cnt <= (ser_data_mod_o == 4'd0) ? 16 : int'(ser_data_mod_o);
        end
    end

    assign ser_busy_i = ser_force || (ser_cnt != 0);

    function automatic void push_cyc(logic [3:0] rdy, logic val, logic [3:0] done,
                                     logic [3:0] err, logic busy, logic gchk, logic [1:0] gnt,
                                     logic chk, logic [15:0] d, logic [3:0] m);
        exp_t e;
        e.rdy = rdy; e.val = val; e.done = done; e.err = err; e.busy = busy;
        e.gchk = gchk; e.gnt = gnt; e.chk = chk; e.data = d; e.mod = m;
        exp_q.push_back(e);
    endfunction

    function automatic void push_idle(int n);
        for (int i = 0; i < n; i++) push_cyc(4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    endfunction

    function automatic void push_xfer(int r, logic [15:0] d, logic [3:0] m);
        int         len;
        logic [3:0] oh;
        len   = (m == 4'd0) ? 16 : int'(m);
        oh    = 4'd0;
        oh[r] = 1'b1;
        push_cyc(oh, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, d, m);
        push_cyc(4'd0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'(r), 1'b1, d, m);
        for (int c = 2; c <= len + 2; c++) push_cyc(4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'(r), 1'b0, d, m);
        push_cyc(4'd0, 1'b0, oh, 4'd0, 1'b1, 1'b1, 2'(r), 1'b0, d, m);
    endfunction

    function automatic void push_reject(int r);
        logic [3:0] oh;
        oh    = 4'd0;
        oh[r] = 1'b1;
        push_cyc(oh, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
        push_cyc(4'd0, 1'b0, 4'd0, oh, 1'b1, 1'b1, 2'(r), 1'b0, 16'd0, 4'd0);
    endfunction

    function automatic void push_timeout(int r, logic [15:0] d, logic [3:0] m);
        logic [3:0] oh;
        oh    = 4'd0;
        oh[r] = 1'b1;
        push_cyc(oh, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, d, m);
        push_cyc(4'd0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'(r), 1'b1, d, m);
        for (int c = 0; c < 4; c++) push_cyc(4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'(r), 1'b0, d, m);
        push_cyc(4'd0, 1'b0, 4'd0, oh, 1'b1, 1'b1, 2'(r), 1'b0, d, m);
    endfunction

    task automatic set_req(input int k, input logic [15:0] d, input logic [3:0] m);
        req_data_i[k*16 +: 16] = d;
        req_mod_i[k*4 +: 4]    = m;
    endtask

    task automatic test_reset;
        exp_t e;
        int   cyc;
        arst_n_i = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 16'h1000 + 16'(k), 4'd3);
        req_val_i = 4'hF;
        repeat (2) begin
            @(negedge clk_i);
            #1;
            n_vec++;
            if ({req_ready_o, req_done_o, req_err_o, ser_data_val_o, busy_o} !== 15'd0) begin
                n_err++;
                $display("FAIL reset_ctl: got rdy=%b done=%b err=%b val=%b busy=%b want all 0",
                         req_ready_o, req_done_o, req_err_o, ser_data_val_o, busy_o);
            end
            n_vec++;
            if ({grant_id_o, ser_data_o, ser_data_mod_o} !== 22'd0) begin
                n_err++;
                $display("FAIL reset_data: got grant=%0d data=%h mod=%0d want 0/0000/0",
                         grant_id_o, ser_data_o, ser_data_mod_o);
            end
        end
        @(negedge clk_i);
        arst_n_i = 1'b1;
        push_xfer(0, 16'h1000, 4'd3);
        push_idle(2);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            #1;
            n_vec++;
            if ({req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o} !== {e.rdy, e.val, e.done, e.err, e.busy}) begin
                n_err++;
                $display("FAIL first_grant cyc%0d: got rdy/val/done/err/busy %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", cyc,
                         req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o, e.rdy, e.val, e.done, e.err, e.busy);
            end
            if (e.chk) begin
                n_vec++;
                if ({ser_data_o, ser_data_mod_o} !== {e.data, e.mod}) begin
                    n_err++;
                    $display("FAIL first_grant_data cyc%0d: got %h/%0d want %h/%0d", cyc, ser_data_o, ser_data_mod_o, e.data, e.mod);
                end
            end
            if (e.gchk) begin
                n_vec++;
                if (grant_id_o !== e.gnt) begin
                    n_err++;
                    $display("FAIL first_grant_id cyc%0d: got %0d want %0d", cyc, grant_id_o, e.gnt);
                end
            end
            @(negedge clk_i);
            req_val_i = 4'd0;
            cyc++;
        end
    endtask

    // Transfer-trace check shared in shape by the scenario tasks below.
    task automatic test_single;
        exp_t e;
        int   cyc;
        set_req(2, 16'hA5C3, 4'd0);
        req_val_i = 4'b0100;
        push_xfer(2, 16'hA5C3, 4'd0);
        push_idle(1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            #1;
            n_vec++;
            if ({req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o} !== {e.rdy, e.val, e.done, e.err, e.busy}) begin
                n_err++;
                $display("FAIL single cyc%0d: got rdy/val/done/err/busy %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", cyc,
                         req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o, e.rdy, e.val, e.done, e.err, e.busy);
            end
            if (e.chk) begin
                n_vec++;
                if ({ser_data_o, ser_data_mod_o} !== {e.data, e.mod}) begin
                    n_err++;
                    $display("FAIL single_data cyc%0d: got %h/%0d want %h/%0d", cyc, ser_data_o, ser_data_mod_o, e.data, e.mod);
                end
            end
            if (e.gchk) begin
                n_vec++;
                if (grant_id_o !== e.gnt) begin
                    n_err++;
                    $display("FAIL single_grant cyc%0d: got %0d want %0d", cyc, grant_id_o, e.gnt);
                end
            end
            @(negedge clk_i);
            req_val_i = req_val_i & ~e.rdy;
            cyc++;
        end
    endtask

    task automatic test_reject;
        exp_t e;
        int   cyc;
        set_req(1, 16'h1111, 4'd2);
        req_val_i = 4'b0010;
        push_reject(1);
        push_idle(1);
        // Second phase: 1 and 2 both valid; pointer should now favour 2.
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                set_req(1, 16'h2222, 4'd3);
                set_req(2, 16'h3333, 4'd3);
                req_val_i = 4'b0110;
                push_xfer(2, 16'h3333, 4'd3);
                push_xfer(1, 16'h2222, 4'd3);
                push_idle(1);
            end
            cyc = 0;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                #1;
                n_vec++;
                if ({req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o} !== {e.rdy, e.val, e.done, e.err, e.busy}) begin
                    n_err++;
                    $display("FAIL reject_p%0d cyc%0d: got rdy/val/done/err/busy %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", phase, cyc,
                             req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o, e.rdy, e.val, e.done, e.err, e.busy);
                end
                if (e.chk) begin
                    n_vec++;
                    if ({ser_data_o, ser_data_mod_o} !== {e.data, e.mod}) begin
                        n_err++;
                        $display("FAIL reject_data_p%0d cyc%0d: got %h/%0d want %h/%0d", phase, cyc, ser_data_o, ser_data_mod_o, e.data, e.mod);
                    end
                end
                if (e.gchk) begin
                    n_vec++;
                    if (grant_id_o !== e.gnt) begin
                        n_err++;
                        $display("FAIL reject_grant_p%0d cyc%0d: got %0d want %0d", phase, cyc, grant_id_o, e.gnt);
                    end
                end
                @(negedge clk_i);
                req_val_i = req_val_i & ~e.rdy;
                cyc++;
            end
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        int   cyc;
        ser_mute = 1'b1;
        set_req(3, 16'h4444, 4'd0);
        req_val_i = 4'b1000;
        push_timeout(3, 16'h4444, 4'd0);
        push_idle(1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            #1;
            n_vec++;
            if ({req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o} !== {e.rdy, e.val, e.done, e.err, e.busy}) begin
                n_err++;
                $display("FAIL timeout cyc%0d: got rdy/val/done/err/busy %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", cyc,
                         req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o, e.rdy, e.val, e.done, e.err, e.busy);
            end
            if (e.gchk) begin
                n_vec++;
                if (grant_id_o !== e.gnt) begin
                    n_err++;
                    $display("FAIL timeout_grant cyc%0d: got %0d want %0d", cyc, grant_id_o, e.gnt);
                end
            end
            @(negedge clk_i);
            req_val_i = req_val_i & ~e.rdy;
            cyc++;
        end
        ser_mute = 1'b0;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        set_req(0, 16'h5555, 4'd4);
        req_val_i = 4'b0001;
        push_xfer(0, 16'h5555, 4'd4);
        // Run into WAIT_DONE (cycle 5 of an 8-cycle transfer), then pull reset.
        for (int cyc = 0; cyc < 5; cyc++) begin
            e = exp_q.pop_front();
            #1;
            n_vec++;
            if ({req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o} !== {e.rdy, e.val, e.done, e.err, e.busy}) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got rdy/val/done/err/busy %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", cyc,
                         req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o, e.rdy, e.val, e.done, e.err, e.busy);
            end
            @(negedge clk_i);
            req_val_i = req_val_i & ~e.rdy;
        end
        exp_q.delete();
        arst_n_i = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc != 0) @(negedge clk_i);
            #1;
            n_vec++;
            if ({req_ready_o, req_done_o, req_err_o, ser_data_val_o, busy_o, grant_id_o, ser_data_o, ser_data_mod_o} !== 37'd0) begin
                n_err++;
                $display("FAIL reset_mid_zero cyc%0d: got rdy=%b done=%b err=%b val=%b busy=%b grant=%0d data=%h mod=%0d want all 0",
                         cyc, req_ready_o, req_done_o, req_err_o, ser_data_val_o, busy_o, grant_id_o, ser_data_o, ser_data_mod_o);
            end
        end
        @(negedge clk_i);
        arst_n_i = 1'b1;
    endtask

    task automatic test_round_robin;
        exp_t e;
        int   cyc;
        int   acc;
        set_req(0, 16'h6000, 4'd3);
        set_req(1, 16'h6001, 4'd5);
        set_req(2, 16'h6002, 4'd4);
        set_req(3, 16'h6003, 4'd6);
        req_val_i = 4'hF;
        push_xfer(0, 16'h6000, 4'd3);
        push_xfer(1, 16'h6001, 4'd5);
        push_xfer(2, 16'h6002, 4'd4);
        push_xfer(3, 16'h6003, 4'd6);
        push_xfer(0, 16'h6000, 4'd3);
        push_idle(2);
        cyc = 0;
        acc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            #1;
            n_vec++;
            if ({req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o} !== {e.rdy, e.val, e.done, e.err, e.busy}) begin
                n_err++;
                $display("FAIL round_robin cyc%0d: got rdy/val/done/err/busy %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", cyc,
                         req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o, e.rdy, e.val, e.done, e.err, e.busy);
            end
            if (e.chk) begin
                n_vec++;
                if ({ser_data_o, ser_data_mod_o} !== {e.data, e.mod}) begin
                    n_err++;
                    $display("FAIL round_robin_data cyc%0d: got %h/%0d want %h/%0d", cyc, ser_data_o, ser_data_mod_o, e.data, e.mod);
                end
            end
            if (e.gchk) begin
                n_vec++;
                if (grant_id_o !== e.gnt) begin
                    n_err++;
                    $display("FAIL round_robin_grant cyc%0d: got %0d want %0d", cyc, grant_id_o, e.gnt);
                end
            end
            if (e.rdy != 4'd0) acc++;
            @(negedge clk_i);
            if (acc == 5) req_val_i = 4'd0;
            cyc++;
        end
    endtask

    task automatic test_busy_block;
        exp_t e;
        int   cyc;
        ser_force = 1'b1;
        set_req(2, 16'h7777, 4'd5);
        req_val_i = 4'b0100;
        push_idle(4);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                ser_force = 1'b0;
                push_xfer(2, 16'h7777, 4'd5);
                push_idle(1);
            end
            cyc = 0;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                #1;
                n_vec++;
                if ({req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o} !== {e.rdy, e.val, e.done, e.err, e.busy}) begin
                    n_err++;
                    $display("FAIL busy_block_p%0d cyc%0d: got rdy/val/done/err/busy %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", phase, cyc,
                             req_ready_o, ser_data_val_o, req_done_o, req_err_o, busy_o, e.rdy, e.val, e.done, e.err, e.busy);
                end
                if (e.chk) begin
                    n_vec++;
                    if ({ser_data_o, ser_data_mod_o} !== {e.data, e.mod}) begin
                        n_err++;
                        $display("FAIL busy_block_data cyc%0d: got %h/%0d want %h/%0d", cyc, ser_data_o, ser_data_mod_o, e.data, e.mod);
                    end
                end
                if (e.gchk) begin
                    n_vec++;
                    if (grant_id_o !== e.gnt) begin
                        n_err++;
                        $display("FAIL busy_block_grant cyc%0d: got %0d want %0d", cyc, grant_id_o, e.gnt);
                    end
                end
                @(negedge clk_i);
                req_val_i = req_val_i & ~e.rdy;
                cyc++;
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        arst_n_i   = 1'b0;
        ser_mute   = 1'b0;
        ser_force  = 1'b0;
        req_data_i = '0;
        req_mod_i  = '0;
        req_val_i  = '0;
        test_reset;
        test_single;
        test_reject;
        test_timeout;
        test_reset_mid;
        test_round_robin;
        test_busy_block;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
